pe_packetizer_mc: RTL and testbench
===================================

PE_PACKETIZER_MC -- requirements
Module: pe_packetizer_mc

Interface
REQ-001 SHALL have parameter FILTER_WIDTH, default 8: sets packet width PKT_W = 5*FILTER_WIDTH+13.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 13: residue width.
REQ-003 SHALL have parameter NUM_DEST, default 4, legal 1..4: number of multicast destinations.
REQ-004 SHALL have parameter DEST_DIR, default 0: packed [2*NUM_DEST-1:0] direction field per destination; entry i at bits [2i+1:2i].
REQ-005 SHALL have parameter DEST_XHOP, default 0: packed [3*NUM_DEST-1:0] x-hop per destination.
REQ-006 SHALL have parameter DEST_YHOP, default 0: packed [3*NUM_DEST-1:0] y-hop per destination.
REQ-007 SHALL have parameter PE_NODE, default 0: 2-bit source node id.
REQ-008 SHALL have parameters ACK_DIR, ACK_XHOP, ACK_YHOP, default 0: ack packet routing fields (2, 3, 3 bits).
REQ-009 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-010 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-012 SHALL have ports in_timestep (input, 1), in_outspike (input, 1), in_residue (input, OUTPUT_WIDTH), in_conv_loc (input, CL_W = PKT_W-12-OUTPUT_WIDTH).
REQ-013 SHALL have port in_dest_mask, input, NUM_DEST: bit i enables destination i for this result.
REQ-014 SHALL have ports pkt_valid (output, 1), pkt_ready (input, 1), pkt_data (output, PKT_W): output handshake.
REQ-015 SHALL have port pkt_count, output, 16: number of packets sent, data and ack.

Function
REQ-016 Transfer SHALL occur on a rising edge with valid and ready both high, on either interface.
REQ-017 FSM states SHALL be IDLE, SEND_DATA, SEND_ACK; in_ready=1 only in IDLE.
REQ-018 On input transfer, all in_* fields SHALL be captured into registers; later input changes SHALL not affect the packets.
REQ-019 From IDLE on transfer: if mask!=0 go to SEND_DATA at lowest set index; else if timestep=1 go to SEND_ACK; else stay in IDLE, drop the result, send no packet.
REQ-020 Data packet for destination i SHALL be {conv_loc, residue, PE_NODE[1:0], outspike, timestep, YHOP_i, XHOP_i, DIR_i}, with dir at [1:0], x-hop at [4:2], y-hop at [7:5], timestep at [8], outspike at [9], node at [11:10], residue at [11+OUTPUT_WIDTH:12], conv_loc in the MSBs.
REQ-021 Ack packet SHALL be {zeros, PE_NODE[1:0], 1'b1, ACK_YHOP, ACK_XHOP, ACK_DIR}, with ack flag at [8] and node at [10:9].
REQ-022 pkt_valid SHALL rise the cycle after the state entry; pkt_data and pkt_valid SHALL be registered and held stable until pkt_ready is high.
REQ-023 In SEND_DATA, after each output transfer the block SHALL advance to the next higher set mask bit with no idle cycle; after the highest one, go to SEND_ACK if timestep=1, else IDLE.
REQ-024 SEND_ACK SHALL emit exactly one ack packet, then return to IDLE.
REQ-025 Latency: first packet valid 1 cycle after input transfer; k packets with pkt_ready held high SHALL take k cycles; in_ready SHALL reassert the cycle after the last output transfer.
REQ-026 Order SHALL be data packets by ascending destination index, ack last.
REQ-027 pkt_count SHALL increment by 1 per output transfer and saturate at 16'hFFFF.
REQ-028 Mask bits above NUM_DEST-1 do not exist; with NUM_DEST=1 the FSM SHALL degenerate to at most data+ack.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously set state=IDLE, pkt_valid=0, pkt_data=0, pkt_count=0, and clear the captured registers; in_ready SHALL be 1 after release.
REQ-030 Reset during SEND_DATA/SEND_ACK SHALL abort the sequence; no remaining packet SHALL be emitted after release.

Verification
REQ-031 NUM_DEST=4, mask=4'b1011, timestep=0, pkt_ready=1 -> 3 packets in consecutive cycles for dest 0,1,3, no ack, pkt_count=3.
REQ-032 mask=4'b0100, timestep=1, residue=13'h1ABC, outspike=1 -> dest-2 data packet with [8]=1, [9]=1, residue field 13'h1ABC, then ack packet with [8]=1, [10:9]=PE_NODE, upper bits 0.
REQ-033 mask=0, timestep=0 -> no pkt_valid, in_ready stays 1; mask=0, timestep=1 -> ack only.
REQ-034 pkt_ready low for 5 cycles mid-sequence -> pkt_data stable, no packet lost or duplicated, in_ready=0 throughout.
REQ-035 rst_n pulled low between packets 1 and 2 of a 4-packet sequence -> pkt_valid=0 immediately, pkt_count=0, after release only new inputs produce packets.
REQ-036 pkt_count preloaded via 65535 transfers, then 1 more -> stays 16'hFFFF.

Source files
------------

// File: rtl/pe_packetizer_mc.sv
// pe_packetizer_mc: turns one PE result into multicast data packets plus an optional ack packet.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid/in_ready            : result handshake (ready only while idle)
//   in_timestep, in_outspike,
//   in_residue, in_conv_loc      : result fields, captured on transfer
//   in_dest_mask                 : per-destination enable for this result
//   pkt_valid/pkt_ready/pkt_data : registered packet output stream
//   pkt_count                    : saturating count of packets sent
module pe_packetizer_mc #(
    parameter int FILTER_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 13,
    parameter int NUM_DEST     = 4,
    parameter logic [2*NUM_DEST-1:0] DEST_DIR  = '0,
    parameter logic [3*NUM_DEST-1:0] DEST_XHOP = '0,
    parameter logic [3*NUM_DEST-1:0] DEST_YHOP = '0,
    parameter logic [1:0] PE_NODE  = 2'd0,
    parameter logic [1:0] ACK_DIR  = 2'd0,
    parameter logic [2:0] ACK_XHOP = 3'd0,
    parameter logic [2:0] ACK_YHOP = 3'd0,
    localparam int PKT_W = 5*FILTER_WIDTH+13,
    localparam int CL_W  = PKT_W-12-OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_timestep,
    input  logic                    in_outspike,
    input  logic [OUTPUT_WIDTH-1:0] in_residue,
    input  logic [CL_W-1:0]         in_conv_loc,
    input  logic [NUM_DEST-1:0]     in_dest_mask,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [PKT_W-1:0]        pkt_data,
    output logic [15:0]             pkt_count
);
    typedef enum logic [1:0] {IDLE, SEND_DATA, SEND_ACK} state_t;

    localparam logic [PKT_W-1:0] ACK_PKT = {{(PKT_W-11){1'b0}}, PE_NODE, 1'b1, ACK_YHOP, ACK_XHOP, ACK_DIR};

    state_t                  state_q, state_d;
    logic [NUM_DEST-1:0]     rem_q, rem_d;
    logic                    ts_q, ts_d, os_q, os_d;
    logic [OUTPUT_WIDTH-1:0] res_q, res_d;
    logic [CL_W-1:0]         cl_q, cl_d;
    logic                    valid_q, valid_d;
    logic [PKT_W-1:0]        data_q, data_d;
    logic [15:0]             cnt_q;

    function automatic logic [1:0] lowest(input logic [NUM_DEST-1:0] m);
        lowest = 2'd0;
        for (int k = NUM_DEST-1; k >= 0; k--)
            if (m[k]) lowest = 2'(k);
    endfunction

    function automatic logic [PKT_W-1:0] data_pkt(input logic [1:0] i, input logic [CL_W-1:0] cl,
                                                  input logic [OUTPUT_WIDTH-1:0] r, input logic os, input logic ts);
        data_pkt = {cl, r, PE_NODE, os, ts, DEST_YHOP[3*i +: 3], DEST_XHOP[3*i +: 3], DEST_DIR[2*i +: 2]};
    endfunction

    assign in_ready  = state_q == IDLE;
    assign pkt_valid = valid_q;
    assign pkt_data  = data_q;
    assign pkt_count = cnt_q;

    // The next packet is loaded on the same edge that enters a send state or
    // completes the previous transfer, so back-to-back packets need no gap.
    // m & (m-1) clears the lowest set bit, leaving the destinations still owed.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ts_d    = ts_q;
        os_d    = os_q;
        res_d   = res_q;
        cl_d    = cl_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (in_valid) begin
                ts_d  = in_timestep;
                os_d  = in_outspike;
                res_d = in_residue;
                cl_d  = in_conv_loc;
                rem_d = in_dest_mask & (in_dest_mask - NUM_DEST'(1));
                if (|in_dest_mask) begin
                    state_d = SEND_DATA;
                    valid_d = 1'b1;
                    data_d  = data_pkt(lowest(in_dest_mask), in_conv_loc, in_residue, in_outspike, in_timestep);
                end else if (in_timestep) begin
                    state_d = SEND_ACK;
                    valid_d = 1'b1;
                    data_d  = ACK_PKT;
                end
            end
            SEND_DATA: if (pkt_ready) begin
                if (|rem_q) begin
                    rem_d  = rem_q & (rem_q - NUM_DEST'(1));
                    data_d = data_pkt(lowest(rem_q), cl_q, res_q, os_q, ts_q);
                end else if (ts_q) begin
                    state_d = SEND_ACK;
                    data_d  = ACK_PKT;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            SEND_ACK: if (pkt_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ts_q    <= 1'b0;
            os_q    <= 1'b0;
            res_q   <= '0;
            cl_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ts_q    <= ts_d;
            os_q    <= os_d;
            res_q   <= res_d;
            cl_q    <= cl_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            if (valid_q && pkt_ready && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_pe_packetizer_mc.sv
// tb_pe_packetizer_mc: directed checks of multicast ordering, ack, stall, reset abort and count saturation.
module tb_pe_packetizer_mc;
    localparam logic [52:0] ACK = 53'h5D5;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_timestep = 0, in_outspike = 0;
    logic [12:0] in_residue = 0;
    logic [27:0] in_conv_loc = 0;
    logic [3:0]  in_dest_mask = 0;
    logic        pkt_valid, pkt_ready = 0;
    logic [52:0] pkt_data;
    logic [15:0] pkt_count;
    int          tests = 0, fails = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    pe_packetizer_mc #(
        .FILTER_WIDTH(8), .OUTPUT_WIDTH(13), .NUM_DEST(4),
        .DEST_DIR(8'b11100100), .DEST_XHOP(12'o4321), .DEST_YHOP(12'o4567),
        .PE_NODE(2'd2), .ACK_DIR(2'd1), .ACK_XHOP(3'd5), .ACK_YHOP(3'd6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_timestep(in_timestep), .in_outspike(in_outspike), .in_residue(in_residue),
        .in_conv_loc(in_conv_loc), .in_dest_mask(in_dest_mask),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_count(pkt_count)
    );

    // destination i: dir=i, xhop=i+1, yhop=7-i
    function automatic logic [52:0] exp_data(input int i, input logic [27:0] cl, input logic [12:0] r,
                                             input logic os, input logic ts);
        logic [52:0] p;
        p = '0;
        p[1:0]   = 2'(i);
        p[4:2]   = 3'(i + 1);
        p[7:5]   = 3'(7 - i);
        p[8]     = ts;
        p[9]     = os;
        p[11:10] = 2'd2;
        p[24:12] = r;
        p[52:25] = cl;
        return p;
    endfunction

    task automatic send(input logic [3:0] m, input logic ts, input logic os, input logic [12:0] r, input logic [27:0] cl);
        in_valid = 1; in_dest_mask = m; in_timestep = ts; in_outspike = os; in_residue = r; in_conv_loc = cl;
        @(posedge clk); #1;
        in_valid = 0; in_dest_mask = 4'hF; in_timestep = ~ts; in_outspike = ~os; in_residue = ~r; in_conv_loc = ~cl;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (pkt_valid !== 1'b0 || pkt_data !== 53'd0 || pkt_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h count=%h, expected 0/0/0", pkt_valid, pkt_data, pkt_count);
        end
        rst_n = 1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b valid=%b, expected 1/0", in_ready, pkt_valid);
        end
    endtask

    task automatic test_multicast;
        logic [52:0] e[$];
        e = '{exp_data(0, 28'h1234567, 13'h0123, 1, 0), exp_data(1, 28'h1234567, 13'h0123, 1, 0),
              exp_data(3, 28'h1234567, 13'h0123, 1, 0)};
        pkt_ready = 1;
        send(4'b1011, 0, 1, 13'h0123, 28'h1234567);
        foreach (e[k]) begin
            tests++;
            if (pkt_valid !== 1'b1 || pkt_data !== e[k]) begin
                fails++;
                $display("FAIL multicast_pkt%0d: valid=%b data=%h, expected 1 %h", k, pkt_valid, pkt_data, e[k]);
            end
            @(posedge clk); #1;
        end
        exp_cnt += 3;
        tests++;
        if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL multicast_end: valid=%b in_ready=%b count=%0d, expected 0/1/%0d", pkt_valid, in_ready, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_data_ack;
        logic [52:0] e[$];
        e = '{exp_data(2, 28'hABCDEF0, 13'h1ABC, 1, 1), ACK};
        send(4'b0100, 1, 1, 13'h1ABC, 28'hABCDEF0);
        foreach (e[k]) begin
            tests++;
            if (pkt_valid !== 1'b1 || pkt_data !== e[k]) begin
                fails++;
                $display("FAIL data_ack_pkt%0d: valid=%b data=%h, expected 1 %h", k, pkt_valid, pkt_data, e[k]);
            end
            @(posedge clk); #1;
        end
        exp_cnt += 2;
        tests++;
        if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL data_ack_end: valid=%b in_ready=%b count=%0d, expected 0/1/%0d", pkt_valid, in_ready, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_drop_and_ack_only;
        send(4'b0000, 0, 1, 13'h0AAA, 28'h5555555);
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL drop_cycle%0d: valid=%b in_ready=%b, expected 0/1", c, pkt_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        send(4'b0000, 1, 1, 13'h1FFF, 28'hFFFFFFF);
        tests++;
        if (pkt_valid !== 1'b1 || pkt_data !== ACK) begin
            fails++;
            $display("FAIL ack_only: valid=%b data=%h, expected 1 %h", pkt_valid, pkt_data, ACK);
        end
        @(posedge clk); #1;
        exp_cnt += 1;
        tests++;
        if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL ack_only_end: valid=%b in_ready=%b count=%0d, expected 0/1/%0d", pkt_valid, in_ready, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_stall;
        logic [52:0] e[$];
        e = '{exp_data(0, 28'h0000555, 13'h0F0F, 0, 1), exp_data(1, 28'h0000555, 13'h0F0F, 0, 1),
              exp_data(2, 28'h0000555, 13'h0F0F, 0, 1), exp_data(3, 28'h0000555, 13'h0F0F, 0, 1), ACK};
        pkt_ready = 0;
        send(4'b1111, 1, 0, 13'h0F0F, 28'h0000555);
        tests++;
        if (pkt_valid !== 1'b1 || pkt_data !== e[0]) begin
            fails++;
            $display("FAIL stall_first: valid=%b data=%h, expected 1 %h", pkt_valid, pkt_data, e[0]);
        end
        pkt_ready = 1;
        @(posedge clk); #1;
        pkt_ready = 0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (pkt_valid !== 1'b1 || pkt_data !== e[1] || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: valid=%b data=%h in_ready=%b, expected 1 %h 0", c, pkt_valid, pkt_data, in_ready, e[1]);
            end
            @(posedge clk); #1;
        end
        pkt_ready = 1;
        for (int k = 1; k < 5; k++) begin
            tests++;
            if (pkt_valid !== 1'b1 || pkt_data !== e[k]) begin
                fails++;
                $display("FAIL stall_pkt%0d: valid=%b data=%h, expected 1 %h", k, pkt_valid, pkt_data, e[k]);
            end
            @(posedge clk); #1;
        end
        exp_cnt += 5;
        tests++;
        if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL stall_end: valid=%b in_ready=%b count=%0d, expected 0/1/%0d", pkt_valid, in_ready, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [52:0] e0;
        e0 = exp_data(0, 28'h0C0FFEE, 13'h0042, 1, 0);
        pkt_ready = 1;
        send(4'b1111, 0, 1, 13'h0333, 28'h0BADBAD);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        exp_cnt = 0;
        tests++;
        if (pkt_valid !== 1'b0 || pkt_count !== 16'd0 || pkt_data !== 53'd0) begin
            fails++;
            $display("FAIL reset_mid_async: valid=%b count=%0d data=%h, expected 0/0/0", pkt_valid, pkt_count, pkt_data);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tests++;
            if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_mid_quiet%0d: valid=%b in_ready=%b, expected 0/1", c, pkt_valid, in_ready);
            end
        end
        send(4'b0001, 0, 1, 13'h0042, 28'h0C0FFEE);
        tests++;
        if (pkt_valid !== 1'b1 || pkt_data !== e0) begin
            fails++;
            $display("FAIL reset_mid_new: valid=%b data=%h, expected 1 %h", pkt_valid, pkt_data, e0);
        end
        @(posedge clk); #1;
        exp_cnt += 1;
        tests++;
        if (pkt_valid !== 1'b0 || pkt_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL reset_mid_end: valid=%b count=%0d, expected 0/%0d", pkt_valid, pkt_count, exp_cnt);
        end
    endtask

    task automatic test_saturate;
        int  n = exp_cnt;
        bit  mid = 0;
        pkt_ready = 1;
        in_valid = 1; in_dest_mask = 4'hF; in_timestep = 1; in_outspike = 0; in_residue = 0; in_conv_loc = 0;
        for (int c = 0; c < 90000 && n < 65535; c++) begin
            if (pkt_valid) n++;
            @(posedge clk); #1;
            if (n == 40000 && !mid) begin
                mid = 1;
                tests++;
                if (pkt_count !== 16'd40000) begin
                    fails++;
                    $display("FAIL count_mid: count=%0d, expected 40000", pkt_count);
                end
            end
        end
        tests++;
        if (n < 65535 || pkt_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL count_full: count=%h after %0d transfers, expected ffff after 65535", pkt_count, n);
        end
        for (int c = 0; c < 10 && !pkt_valid; c++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (pkt_valid !== 1'b1) begin
            fails++;
            $display("FAIL count_extra_timeout: valid=%b, expected 1", pkt_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (pkt_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL count_saturate: count=%h, expected ffff", pkt_count);
        end
        in_valid = 0;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL saturate_drain: valid=%b in_ready=%b count=%h, expected 0/1/ffff", pkt_valid, in_ready, pkt_count);
        end
    endtask

    initial begin
        test_reset;
        test_multicast;
        test_data_ack;
        test_drop_and_ack_only;
        test_stall;
        test_reset_mid;
        test_saturate;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
